// File: rtl/pts_128_to_8.sv
// Parallel-to-serial converter: captures an IN_WIDTH-bit block and presents it
// OUT_WIDTH bits at a time, least-significant chunk first, bit-reversed on output.
module pts_128_to_8 #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 shift_enable,
  input  logic                 load_enable,
  input  logic [IN_WIDTH-1:0]  parallel_in,
  output logic [OUT_WIDTH-1:0] serial_out
);

  // The block must split into a whole number of output chunks.
  if ((IN_WIDTH % OUT_WIDTH) != 0 || IN_WIDTH < OUT_WIDTH) begin : g_width_check
    $error("pts_128_to_8: IN_WIDTH must be a non-zero multiple of OUT_WIDTH");
  end

  logic [IN_WIDTH-1:0] data_q;

  // n_rst is active-high despite its name. Load takes priority over shift;
  // shifting pulls zeros into the top chunk so an exhausted block reads as zero.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      data_q <= '0;
    end else if (load_enable) begin
      data_q <= parallel_in;
    end else if (shift_enable) begin
      data_q <= data_q >> OUT_WIDTH;
    end
  end

  // Downstream expects the MSB of each chunk on bit 0, so reverse the low chunk.
  always_comb begin
    serial_out = '0;
    for (int j = 0; j < OUT_WIDTH; j++) begin
      serial_out[j] = data_q[OUT_WIDTH-1-j];
    end
  end

endmodule

// File: tb/tb_pts_128_to_8.sv
// Directed bench for pts_128_to_8: reset, load priority, byte order, exhaustion,
// idle hold and asynchronous mid-stream reset.
module tb_pts_128_to_8;

  logic         clk;
  logic         n_rst;
  logic         shift_enable;
  logic         load_enable;
  logic [127:0] parallel_in;
  logic [7:0]   serial_out;

  int checks;
  int failures;

  logic [127:0] ramp;
  logic [7:0]   rev_tab [16];

  pts_128_to_8 #(.IN_WIDTH(128), .OUT_WIDTH(8)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .shift_enable (shift_enable),
    .load_enable  (load_enable),
    .parallel_in  (parallel_in),
    .serial_out   (serial_out)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and land 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst        = 1'b1;
    load_enable  = 1'b1;
    shift_enable = 1'b0;
    parallel_in  = '1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (serial_out !== 8'h00) begin
        failures++;
        $display("FAIL reset_held cycle %0d: got %h expected 00", i, serial_out);
      end
    end
    n_rst = 1'b0;
    cycle();
    checks++;
    if (serial_out !== 8'hFF) begin
      failures++;
      $display("FAIL reset_release_load: got %h expected ff", serial_out);
    end
  endtask

  task automatic test_pattern_hold();
    parallel_in  = {16{8'h55}};
    load_enable  = 1'b1;
    shift_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      checks++;
      if (serial_out !== 8'hAA) begin
        failures++;
        $display("FAIL pattern_hold cycle %0d: got %h expected aa", i, serial_out);
      end
    end
    load_enable  = 1'b0;
    shift_enable = 1'b0;
  endtask

  task automatic test_load_priority();
    parallel_in  = ramp;
    load_enable  = 1'b1;
    shift_enable = 1'b0;
    cycle();
    shift_enable = 1'b1;
    cycle();
    checks++;
    if (serial_out !== 8'h00) begin
      failures++;
      $display("FAIL load_priority: got %h expected 00", serial_out);
    end
    load_enable = 1'b0;
    cycle();
    checks++;
    if (serial_out !== 8'h80) begin
      failures++;
      $display("FAIL load_priority_then_shift: got %h expected 80", serial_out);
    end
    shift_enable = 1'b0;
  endtask

  task automatic test_byte_order_and_exhaustion();
    parallel_in  = ramp;
    load_enable  = 1'b1;
    shift_enable = 1'b0;
    cycle();
    checks++;
    if (serial_out !== rev_tab[0]) begin
      failures++;
      $display("FAIL byte_order k=0: got %h expected %h", serial_out, rev_tab[0]);
    end
    load_enable  = 1'b0;
    parallel_in  = '1;
    shift_enable = 1'b1;
    for (int k = 1; k < 16; k++) begin
      cycle();
      checks++;
      if (serial_out !== rev_tab[k]) begin
        failures++;
        $display("FAIL byte_order k=%0d: got %h expected %h", k, serial_out, rev_tab[k]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (serial_out !== 8'h00) begin
        failures++;
        $display("FAIL exhaustion shift %0d: got %h expected 00", 16 + i, serial_out);
      end
    end
    shift_enable = 1'b0;
  endtask

  task automatic test_hold();
    parallel_in  = 128'h1;
    load_enable  = 1'b1;
    shift_enable = 1'b0;
    cycle();
    load_enable = 1'b0;
    parallel_in = '0;
    checks++;
    if (serial_out !== 8'h80) begin
      failures++;
      $display("FAIL hold_load: got %h expected 80", serial_out);
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (serial_out !== 8'h80) begin
        failures++;
        $display("FAIL hold_idle cycle %0d: got %h expected 80", i, serial_out);
      end
    end
  endtask

  task automatic test_mid_stream_reset();
    parallel_in  = ramp;
    load_enable  = 1'b1;
    shift_enable = 1'b0;
    cycle();
    load_enable  = 1'b0;
    shift_enable = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if (serial_out !== 8'hC0) begin
      failures++;
      $display("FAIL mid_stream_pre_reset: got %h expected c0", serial_out);
    end
    // Pulse reset between edges; output must clear without waiting for a clock.
    #2;
    n_rst = 1'b1;
    #1;
    checks++;
    if (serial_out !== 8'h00) begin
      failures++;
      $display("FAIL mid_stream_async_reset: got %h expected 00", serial_out);
    end
    #1;
    n_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (serial_out !== 8'h00) begin
        failures++;
        $display("FAIL mid_stream_post_reset shift %0d: got %h expected 00", i, serial_out);
      end
    end
    shift_enable = 1'b0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    n_rst        = 1'b1;
    load_enable  = 1'b0;
    shift_enable = 1'b0;
    parallel_in  = '0;
    ramp         = 128'h0F0E0D0C0B0A09080706050403020100;
    rev_tab      = '{8'h00, 8'h80, 8'h40, 8'hC0, 8'h20, 8'hA0, 8'h60, 8'hE0,
                     8'h10, 8'h90, 8'h50, 8'hD0, 8'h30, 8'hB0, 8'h70, 8'hF0};
    #1;

    test_reset();
    test_pattern_hold();
    test_load_priority();
    test_byte_order_and_exhaustion();
    test_hold();
    test_mid_stream_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
